// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } state_e;

  localparam int unsigned MD_LATENCY_DEFAULT = 32;
  localparam int unsigned CNT_BITS_DEFAULT   = 32;

  // Width needed to hold the reload value MD_LATENCY-1 (MD_LATENCY >= 2).
  function automatic int unsigned md_cnt_width(input int unsigned latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard requests from the pipeline and per-stage enable/valid controls back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_BITS = 32
) ();

  logic                load_use;
  logic                branch_taken;
  logic                md_start;
  logic                halt_req;
  logic                resume;
  logic                pc_en;
  logic                ifid_en;
  logic                ifid_valid;
  logic                idex_en;
  logic                idex_valid;
  logic                exmem_en;
  logic                exmem_valid;
  logic                memwb_en;
  logic                memwb_valid;
  logic                halted;
  logic [CNT_BITS-1:0] stall_cnt;

  modport master (
    output load_use, branch_taken, md_start, halt_req, resume,
    input  pc_en, ifid_en, ifid_valid, idex_en, idex_valid,
           exmem_en, exmem_valid, memwb_en, memwb_valid, halted, stall_cnt
  );

  modport slave (
    input  load_use, branch_taken, md_start, halt_req, resume,
    output pc_en, ifid_en, ifid_valid, idex_en, idex_valid,
           exmem_en, exmem_valid, memwb_en, memwb_valid, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Loadable down-counter tracking remaining mul/div occupancy of EX.
module md_busy_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/squash controller for the PC and the four inter-stage registers.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_BITS   = CNT_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int unsigned MDW = md_cnt_width(MD_LATENCY);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic                md_load, md_dec, md_zero;
  logic                pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                ifid_valid, idex_valid, exmem_valid, memwb_valid;
  logic                halted;

  md_busy_timer #(.W(MDW)) u_md_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (md_load),
    .load_val_i (MDW'(MD_LATENCY - 1)),
    .dec_i      (md_dec),
    .zero_o     (md_zero)
  );

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_valid  = 1'b1;
    idex_valid  = 1'b1;
    exmem_valid = 1'b1;
    memwb_valid = 1'b1;
    halted      = 1'b0;
    md_load     = 1'b0;
    md_dec      = 1'b0;

    unique case (state_q)
      HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        halted   = 1'b1;
        if (hz.resume) state_d = RUN;
      end
      MD_BUSY: begin
        // Zero count is the release cycle: everything advances with the result.
        if (md_zero) begin
          state_d = RUN;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          exmem_valid = 1'b0;
          md_dec      = 1'b1;
        end
      end
      default: begin
        if (hz.halt_req) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          state_d  = HALT;
        end else if (hz.branch_taken) begin
          ifid_valid = 1'b0;
          idex_valid = 1'b0;
        end else if (hz.md_start) begin
          md_load = 1'b1;
          state_d = MD_BUSY;
        end else if (hz.load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_valid = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_valid  = ifid_valid;
  assign hz.idex_en     = idex_en;
  assign hz.idex_valid  = idex_valid;
  assign hz.exmem_en    = exmem_en;
  assign hz.exmem_valid = exmem_valid;
  assign hz.memwb_en    = memwb_en;
  assign hz.memwb_valid = memwb_valid;
  assign hz.halted      = halted;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MD_LATENCY=4.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam int unsigned CB  = 32;

  // Packed view: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
  //               ifid_valid, idex_valid, exmem_valid, memwb_valid}
  localparam logic [8:0] V_ALL    = 9'b11111_1111;
  localparam logic [8:0] V_LDUSE  = 9'b00111_1011;
  localparam logic [8:0] V_BRANCH = 9'b11111_0011;
  localparam logic [8:0] V_MDBUSY = 9'b00001_1101;
  localparam logic [8:0] V_HALTN  = 9'b00001_1111;
  localparam logic [8:0] V_HALT   = 9'b00000_1111;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  pipeline_hazard_ctrl_if #(.CNT_BITS(CB)) hz ();

  pipeline_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_valid, hz.idex_valid, hz.exmem_valid, hz.memwb_valid};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.load_use     = 1'b0;
    hz.branch_taken = 1'b0;
    hz.md_start     = 1'b0;
    hz.halt_req     = 1'b0;
    hz.resume       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== V_ALL || hz.halted !== 1'b0 || hz.stall_cnt !== 32'd0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got ctl=%b halted=%b cnt=%0d want ctl=%b halted=0 cnt=0",
                 i, obs, hz.halted, hz.stall_cnt, V_ALL);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    hz.load_use = 1'b1;
    #1;
    total++;
    if (obs !== V_LDUSE) begin
      bad++;
      $display("FAIL load_use_ctl: got %b want %b", obs, V_LDUSE);
    end
    step();
    hz.load_use = 1'b0;
    #1;
    total++;
    if (obs !== V_ALL || hz.stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL load_use_after: got ctl=%b cnt=%0d want ctl=%b cnt=1", obs, hz.stall_cnt, V_ALL);
    end
    step();
  endtask

  task automatic test_branch();
    hz.load_use     = 1'b1;
    hz.branch_taken = 1'b1;
    #1;
    total++;
    if (obs !== V_BRANCH) begin
      bad++;
      $display("FAIL branch_ctl: got %b want %b", obs, V_BRANCH);
    end
    step();
    clear_inputs();
    #1;
    total++;
    if (obs !== V_ALL || hz.stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL branch_after: got ctl=%b cnt=%0d want ctl=%b cnt=1", obs, hz.stall_cnt, V_ALL);
    end
    step();
  endtask

  task automatic test_muldiv();
    hz.md_start = 1'b1;
    #1;
    total++;
    if (obs !== V_ALL) begin
      bad++;
      $display("FAIL md_start_cycle: got %b want %b", obs, V_ALL);
    end
    step();
    hz.md_start = 1'b0;
    hz.load_use = 1'b1;   // must be ignored while busy
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== V_MDBUSY || hz.halted !== 1'b0) begin
        bad++;
        $display("FAIL md_busy[%0d]: got ctl=%b halted=%b want ctl=%b halted=0", i, obs, hz.halted, V_MDBUSY);
      end
      step();
    end
    #1;
    total++;
    if (obs !== V_ALL) begin
      bad++;
      $display("FAIL md_release: got %b want %b", obs, V_ALL);
    end
    step();
    hz.load_use = 1'b0;
    #1;
    total++;
    if (obs !== V_ALL || hz.stall_cnt !== 32'd4) begin
      bad++;
      $display("FAIL md_after: got ctl=%b cnt=%0d want ctl=%b cnt=4", obs, hz.stall_cnt, V_ALL);
    end
    step();
  endtask

  task automatic test_halt();
    hz.halt_req = 1'b1;
    #1;
    total++;
    if (obs !== V_HALTN || hz.halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_cycle_n: got ctl=%b halted=%b want ctl=%b halted=0", obs, hz.halted, V_HALTN);
    end
    step();
    hz.halt_req     = 1'b0;
    hz.branch_taken = 1'b1;   // ignored in HALT
    hz.md_start     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== V_HALT || hz.halted !== 1'b1) begin
        bad++;
        $display("FAIL halt_hold[%0d]: got ctl=%b halted=%b want ctl=%b halted=1", i, obs, hz.halted, V_HALT);
      end
      step();
    end
    hz.resume = 1'b1;
    #1;
    total++;
    if (obs !== V_HALT || hz.halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_resume_cycle: got ctl=%b halted=%b want ctl=%b halted=1", obs, hz.halted, V_HALT);
    end
    step();
    clear_inputs();
    #1;
    total++;
    if (obs !== V_ALL || hz.halted !== 1'b0 || hz.stall_cnt !== 32'd9) begin
      bad++;
      $display("FAIL halt_after_resume: got ctl=%b halted=%b cnt=%0d want ctl=%b halted=0 cnt=9",
               obs, hz.halted, hz.stall_cnt, V_ALL);
    end
    step();
  endtask

  task automatic test_rst_mid_md();
    hz.md_start = 1'b1;
    step();
    hz.md_start = 1'b0;
    #1;
    total++;
    if (obs !== V_MDBUSY) begin
      bad++;
      $display("FAIL rst_md_busy1: got %b want %b", obs, V_MDBUSY);
    end
    step();
    rst = 1'b1;
    #1;
    total++;
    if (obs !== V_MDBUSY) begin
      bad++;
      $display("FAIL rst_md_busy2: got %b want %b", obs, V_MDBUSY);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== V_ALL || hz.stall_cnt !== 32'd0) begin
        bad++;
        $display("FAIL rst_md_after[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=0", i, obs, hz.stall_cnt, V_ALL);
      end
      step();
    end
  endtask

  task automatic test_rst_mid_halt();
    hz.halt_req = 1'b1;
    step();
    hz.halt_req = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (hz.halted !== 1'b1) begin
      bad++;
      $display("FAIL rst_halt_in: got halted=%b want 1", hz.halted);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (obs !== V_ALL || hz.halted !== 1'b0 || hz.stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL rst_halt_after: got ctl=%b halted=%b cnt=%0d want ctl=%b halted=0 cnt=0",
               obs, hz.halted, hz.stall_cnt, V_ALL);
    end
    step();
  endtask

  task automatic test_back_to_back();
    // Two consecutive load_use cycles give two stall cycles.
    hz.load_use = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== V_LDUSE) begin
        bad++;
        $display("FAIL b2b_load_use[%0d]: got %b want %b", i, obs, V_LDUSE);
      end
      step();
    end
    hz.load_use = 1'b0;
    #1;
    total++;
    if (hz.stall_cnt !== 32'd2) begin
      bad++;
      $display("FAIL b2b_cnt: got %0d want 2", hz.stall_cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_halt();
    test_rst_mid_md();
    test_back_to_back();
    test_rst_mid_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
